// File: rtl/usb_rx_decoder.sv
// USB receive decoder: NRZI decode, bit unstuffing with violation check, LSB-first word assembly.
// Latency: one cycle from the last bit of a word (or from the EOP strobe) to word_valid/out_done.
// Backpressure: none; one line bit is consumed in every cycle where bstr_in_ready is high.
module usb_rx_decoder #(
    parameter int WIDTH      = 8,
    parameter int STUFF_LEN  = 6,
    parameter bit IDLE_LEVEL = 1'b1,
    parameter bit UNSTUFF_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bstr_in,
    input  logic                     bstr_in_ready,
    input  logic                     in_done,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    output logic                     out_done,
    output logic [$clog2(WIDTH)-1:0] out_nbits,
    output logic                     stuff_err
);
    localparam int BW = $clog2(WIDTH);
    localparam int OW = $clog2(STUFF_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prev_level;
    logic [OW-1:0]    ones_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift;

    logic dbit;
    logic take;
    logic is_stuff;
    logic accept;
    logic violation;

    // Bit classification: decoded value, and whether it is data, a stuff bit or a violation.
    always_comb begin
        dbit      = (bstr_in == prev_level);
        take      = bstr_in_ready && !in_done && (state != ERROR);
        is_stuff  = UNSTUFF_EN && (ones_cnt == OW'(STUFF_LEN));
        accept    = take && !is_stuff;
        violation = take && is_stuff && dbit;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: EOP always returns to IDLE and overrides any bit in the same cycle.
    always_comb begin
        state_nxt = state;
        if (in_done) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bstr_in_ready) state_nxt = RECV;
                RECV:    if (violation)     state_nxt = ERROR;
                ERROR:   state_nxt = ERROR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: line history, ones run length, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            out_done   <= 1'b0;
            out_nbits  <= '0;
            stuff_err  <= 1'b0;
            prev_level <= IDLE_LEVEL;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
        end else begin
            word_valid <= 1'b0;
            out_done   <= 1'b0;
            stuff_err  <= 1'b0;
            if (in_done) begin
                out_done <= 1'b1;
                if (state == ERROR) begin
                    out_nbits <= '0;
                end else begin
                    out_nbits <= bit_cnt;
                    // Bits above bit_cnt are still zero from the last clear.
                    if (bit_cnt != '0) word_out <= shift;
                end
                prev_level <= IDLE_LEVEL;
                ones_cnt   <= '0;
                bit_cnt    <= '0;
                shift      <= '0;
            end else if (bstr_in_ready) begin
                prev_level <= bstr_in;
                if (violation) begin
                    stuff_err <= 1'b1;
                end else if (take && is_stuff) begin
                    ones_cnt <= '0;
                end else if (accept) begin
                    if (UNSTUFF_EN) ones_cnt <= dbit ? ones_cnt + 1'b1 : '0;
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        word_out   <= {dbit, shift[WIDTH-2:0]};
                        word_valid <= 1'b1;
                        bit_cnt    <= '0;
                        shift      <= '0;
                    end else begin
                        shift[bit_cnt] <= dbit;
                        bit_cnt        <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule
